// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step controller for the five-stage pipeline: forwards hazard-unit
// stall/flush while running, drains and holds the pipeline empty on halt, and counts retirements.
module pipe_run_ctrl #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic             hz_StallF,
  input  logic             hz_StallD,
  input  logic             hz_FlushD,
  input  logic             hz_FlushE,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] RUN         = 2'd0;
  localparam logic [1:0] DRAIN       = 2'd1;
  localparam logic [1:0] STEP_ISSUE  = 2'd2;
  localparam logic [1:0] HALTED      = 2'd3;
  localparam logic [1:0] RESET_STATE = HALT_ON_RESET ? HALTED : RUN;

  // XLEN only exists so every pipeline block takes the same parameter set.
  if (XLEN < 1) begin : g_xlen_unsupported
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       valid_d;
  logic       valid_e;
  logic       valid_m;
  logic       valid_w;
  logic       pipe_empty;

  assign pipe_empty = ~(valid_d | valid_e | valid_m | valid_w);
  assign halted     = (state == HALTED);
  assign retire     = valid_w;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    StallF = hz_StallF;
    StallD = hz_StallD;
    FlushD = hz_FlushD;
    FlushE = hz_FlushE;
    case (state)
      DRAIN: begin
        // Fetch keeps stalling unless a taken redirect must land in the PC to become the resume PC.
        StallF = hz_StallF | ~PCSrcE;
        StallD = hz_StallD;
        FlushD = ~hz_StallD;
      end
      HALTED: begin
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (halt_req) state_nxt = DRAIN;
      DRAIN:      if (pipe_empty) state_nxt = HALTED;
      STEP_ISSUE: if (!hz_StallF) state_nxt = DRAIN;
      HALTED: begin
        if (resume_req)    state_nxt = RUN;
        else if (step_req) state_nxt = STEP_ISSUE;
      end
      default:    state_nxt = RESET_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  // Validity follows the effective (possibly overridden) stall/flush seen by the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d <= 1'b0;
      valid_e <= 1'b0;
      valid_m <= 1'b0;
      valid_w <= 1'b0;
    end else begin
      valid_d <= FlushD ? 1'b0 : (StallD ? valid_d : 1'b1);
      valid_e <= FlushE ? 1'b0 : valid_d;
      valid_m <= valid_e;
      valid_w <= valid_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: three instances (run-from-reset, halt-on-reset,
// 4-bit counter) share hazard inputs; expectations are queued by cycle and checked at negedge.
module tb_pipe_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic halt_a, resume_a, step_a;
  logic step_b, resume_b, halt_b;
  logic hz_stall_f, hz_stall_d, hz_flush_d, hz_flush_e, pc_src_e;

  logic [3:0]  outs_a, outs_b, outs_c;   // {StallF, StallD, FlushD, FlushE}
  logic        halted_a, halted_b, halted_c;
  logic        retire_a, retire_b, retire_c;
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  pipe_run_ctrl #(.XLEN(32), .CNT_W(32), .HALT_ON_RESET(1'b0)) u_a (
    .clk(clk), .reset(reset), .halt_req(halt_a), .resume_req(resume_a), .step_req(step_a),
    .hz_StallF(hz_stall_f), .hz_StallD(hz_stall_d), .hz_FlushD(hz_flush_d), .hz_FlushE(hz_flush_e),
    .PCSrcE(pc_src_e), .StallF(outs_a[3]), .StallD(outs_a[2]), .FlushD(outs_a[1]), .FlushE(outs_a[0]),
    .halted(halted_a), .retire(retire_a), .retire_cnt(cnt_a));

  pipe_run_ctrl #(.XLEN(32), .CNT_W(32), .HALT_ON_RESET(1'b1)) u_b (
    .clk(clk), .reset(reset), .halt_req(halt_b), .resume_req(resume_b), .step_req(step_b),
    .hz_StallF(hz_stall_f), .hz_StallD(hz_stall_d), .hz_FlushD(hz_flush_d), .hz_FlushE(hz_flush_e),
    .PCSrcE(pc_src_e), .StallF(outs_b[3]), .StallD(outs_b[2]), .FlushD(outs_b[1]), .FlushE(outs_b[0]),
    .halted(halted_b), .retire(retire_b), .retire_cnt(cnt_b));

  pipe_run_ctrl #(.XLEN(32), .CNT_W(4), .HALT_ON_RESET(1'b0)) u_c (
    .clk(clk), .reset(reset), .halt_req(halt_a), .resume_req(resume_a), .step_req(step_a),
    .hz_StallF(hz_stall_f), .hz_StallD(hz_stall_d), .hz_FlushD(hz_flush_d), .hz_FlushE(hz_flush_e),
    .PCSrcE(pc_src_e), .StallF(outs_c[3]), .StallD(outs_c[2]), .FlushD(outs_c[1]), .FlushE(outs_c[0]),
    .halted(halted_c), .retire(retire_c), .retire_cnt(cnt_c));

  always #5 clk = ~clk;

  // Cycle 0 is the cycle in which reset is first released.
  int cyc = -3;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_HALTED, F_RETIRE, F_CNT, F_OUTS} field_e;
  typedef struct {
    int          cyc;
    int          dut;
    field_e      fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  localparam int DA = 0, DB = 1, DC = 2;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   done    = 1'b0;

  function automatic void expect_at(input int c, input int d, input field_e f,
                                    input logic [31:0] e, input string n);
    exp_t x;
    int   i = 0;
    x.cyc = c; x.dut = d; x.fld = f; x.exp = e; x.name = n;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, x);
  endfunction

  function automatic logic [31:0] actual(input int d, input field_e f);
    logic [3:0]  o;
    logic        h, r;
    logic [31:0] n;
    if (d == DA)      begin o = outs_a; h = halted_a; r = retire_a; n = cnt_a; end
    else if (d == DB) begin o = outs_b; h = halted_b; r = retire_b; n = cnt_b; end
    else              begin o = outs_c; h = halted_c; r = retire_c; n = {28'd0, cnt_c}; end
    case (f)
      F_HALTED: return {31'd0, h};
      F_RETIRE: return {31'd0, r};
      F_CNT:    return n;
      default:  return {28'd0, o};
    endcase
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 'h%0h, want 'h%0h", name, c, act, exp);
    end
  endtask

  // Monitor: pops every expectation due this cycle; at the end, anything left over is a miss.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      if (x.cyc < cyc) check({x.name, "_late"}, x.cyc, 32'hxxxx_xxxx, x.exp);
      else             check(x.name, x.cyc, actual(x.dut, x.fld), x.exp);
    end
    if (done) begin
      while (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        check({x.name, "_unreached"}, x.cyc, 32'hxxxx_xxxx, x.exp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
    end
  end

  task automatic go(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One step pulse on the halt-on-reset instance in cycle h; k is the retire count afterwards.
  task automatic step_b_at(input int h, input int k);
    go(h);
    step_b = 1'b1;
    expect_at(h,     DB, F_HALTED, 1,     "b_halted_before_step");
    expect_at(h + 1, DB, F_OUTS,   4'b0000, "b_step_issue_passthru");
    expect_at(h + 2, DB, F_OUTS,   4'b1010, "b_step_drain_outs");
    for (int i = 1; i <= 6; i++) expect_at(h + i, DB, F_HALTED, 0, "b_halted_low_in_step");
    expect_at(h + 7, DB, F_HALTED, 1,     "b_halted_back_h7");
    expect_at(h + 4, DB, F_RETIRE, 0,     "b_no_retire_h4");
    expect_at(h + 5, DB, F_RETIRE, 1,     "b_retire_h5");
    expect_at(h + 5, DB, F_CNT,    k - 1, "b_cnt_before");
    expect_at(h + 6, DB, F_CNT,    k,     "b_cnt_after");
    go(h + 1);
    step_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {halt_a, resume_a, step_a, step_b, resume_b, halt_b} = '0;
    {hz_stall_f, hz_stall_d, hz_flush_d, hz_flush_e, pc_src_e} = '0;

    expect_at(-1, DA, F_HALTED, 0,       "a_reset_halted");
    expect_at(-1, DA, F_RETIRE, 0,       "a_reset_retire");
    expect_at(-1, DA, F_CNT,    0,       "a_reset_cnt");
    expect_at(-1, DA, F_OUTS,   4'b0000, "a_reset_outs");
    expect_at(-1, DB, F_HALTED, 1,       "b_reset_halted");
    expect_at(-1, DB, F_OUTS,   4'b1010, "b_reset_outs");

    go(0);
    reset = 1'b0;
    // Straight-line run: first retirement in cycle 4, one per cycle after that.
    expect_at(1,  DA, F_HALTED, 0,  "a_run_halted");
    expect_at(10, DA, F_HALTED, 0,  "a_run_halted");
    expect_at(3,  DA, F_RETIRE, 0,  "a_no_retire_c3");
    expect_at(4,  DA, F_RETIRE, 1,  "a_first_retire");
    expect_at(4,  DA, F_CNT,    0,  "a_cnt_c4");
    expect_at(5,  DA, F_CNT,    1,  "a_cnt_c5");
    expect_at(20, DA, F_RETIRE, 1,  "a_retire_c20");
    expect_at(20, DA, F_CNT,    16, "a_cnt_c20");
    expect_at(21, DA, F_CNT,    17, "a_cnt_after_c20");
    expect_at(19, DC, F_CNT,    15, "c_cnt_15");
    expect_at(20, DC, F_CNT,    0,  "c_cnt_wrap");
    expect_at(20, DC, F_RETIRE, 1,  "c_retire_c20");
    expect_at(21, DC, F_CNT,    1,  "c_cnt_after_wrap");

    step_b_at(5,  1);
    step_b_at(15, 2);
    step_b_at(25, 3);

    go(35);
    hz_stall_f = 1'b1;
    expect_at(35, DA, F_OUTS, 4'b1000, "a_run_passthru");
    go(36);
    hz_stall_f = 1'b0;

    // Halt in cycle 40; a load-use stall hits the first drain cycle, adding one cycle.
    go(40);
    halt_a = 1'b1;
    expect_at(44, DA, F_RETIRE, 0,       "a_drain_bubble_retire");
    expect_at(45, DA, F_RETIRE, 1,       "a_drain_last_retire");
    expect_at(45, DA, F_CNT,    40,      "a_drain_cnt_c45");
    expect_at(45, DA, F_OUTS,   4'b1010, "a_step_ignored_in_drain");
    expect_at(46, DA, F_HALTED, 0,       "a_halted_c46");
    expect_at(47, DA, F_HALTED, 1,       "a_halted_c47");
    expect_at(47, DA, F_CNT,    41,      "a_cnt_frozen_c47");
    expect_at(55, DA, F_HALTED, 1,       "a_still_halted");
    expect_at(55, DA, F_CNT,    41,      "a_cnt_frozen_c55");
    expect_at(47, DC, F_CNT,    9,       "c_cnt_c47");
    expect_at(47, DC, F_HALTED, 1,       "c_halted_c47");
    go(41);
    halt_a = 1'b0;
    {hz_stall_f, hz_stall_d, hz_flush_e} = 3'b111;
    expect_at(41, DA, F_OUTS, 4'b1101, "a_drain_loaduse_outs");
    expect_at(41, DC, F_OUTS, 4'b1101, "c_drain_loaduse_outs");
    expect_at(41, DB, F_OUTS, 4'b1011, "b_halted_override");
    go(42);
    {hz_stall_f, hz_stall_d, hz_flush_e} = 3'b000;
    go(43);
    pc_src_e = 1'b1;
    expect_at(43, DA, F_OUTS, 4'b0010, "a_drain_redirect_stallf0");
    go(44);
    pc_src_e = 1'b0;
    step_a   = 1'b1;
    go(45);
    step_a   = 1'b0;

    // Resume and step together: resume wins, the pipeline refills.
    go(60);
    resume_a = 1'b1;
    step_a   = 1'b1;
    expect_at(61, DA, F_HALTED, 0,       "a_resume_halted_c61");
    expect_at(63, DA, F_OUTS,   4'b0000, "a_resume_not_step");
    expect_at(64, DA, F_RETIRE, 0,       "a_resume_retire_c64");
    expect_at(65, DA, F_RETIRE, 1,       "a_resume_retire_c65");
    expect_at(66, DA, F_RETIRE, 1,       "a_resume_retire_c66");
    expect_at(65, DA, F_CNT,    41,      "a_resume_cnt_c65");
    expect_at(66, DA, F_CNT,    42,      "a_resume_cnt_c66");
    expect_at(67, DA, F_HALTED, 0,       "a_resume_halted_c67");
    expect_at(66, DC, F_CNT,    10,      "c_cnt_c66");
    go(61);
    {resume_a, step_a} = 2'b00;

    // Clean halt with a full, hazard-free pipeline.
    go(70);
    halt_a = 1'b1;
    expect_at(74, DA, F_RETIRE, 1,  "a_clean_last_retire");
    expect_at(75, DA, F_RETIRE, 0,  "a_clean_empty");
    expect_at(75, DA, F_HALTED, 0,  "a_clean_halted_c75");
    expect_at(76, DA, F_HALTED, 1,  "a_clean_halted_c76");
    expect_at(76, DA, F_CNT,    51, "a_clean_cnt_c76");
    expect_at(80, DA, F_CNT,    51, "a_clean_cnt_c80");
    go(71);
    halt_a = 1'b0;

    go(80);
    resume_a = 1'b1;
    go(81);
    resume_a = 1'b0;

    // Asynchronous reset one cycle into a drain.
    go(90);
    halt_a = 1'b1;
    expect_at(91, DA, F_CNT, 57, "a_cnt_before_reset");
    go(91);
    halt_a = 1'b0;
    go(92);
    reset = 1'b1;
    expect_at(92, DA, F_HALTED, 0,       "a_async_halted");
    expect_at(92, DA, F_RETIRE, 0,       "a_async_retire");
    expect_at(92, DA, F_CNT,    0,       "a_async_cnt");
    expect_at(92, DA, F_OUTS,   4'b0000, "a_async_outs");
    expect_at(92, DB, F_HALTED, 1,       "b_async_halted");
    expect_at(92, DB, F_CNT,    0,       "b_async_cnt");
    expect_at(92, DC, F_CNT,    0,       "c_async_cnt");
    go(94);
    reset = 1'b0;
    expect_at(94, DA, F_HALTED, 0, "a_post_reset_run");
    expect_at(96, DB, F_HALTED, 1, "b_post_reset_halted");
    expect_at(97, DA, F_RETIRE, 0, "a_post_reset_no_retire");
    expect_at(98, DA, F_RETIRE, 1, "a_post_reset_retire");
    expect_at(98, DA, F_CNT,    0, "a_post_reset_cnt_c98");
    expect_at(99, DA, F_CNT,    1, "a_post_reset_cnt_c99");

    go(101);
    done = 1'b1;
  end

endmodule
